data_mem_be: RTL and testbench
==============================

DATA_MEM_BE -- requirements
Module: data_mem_be

Interface
REQ-001 Parameter DATA_W, default 32, data word width in bits; SHALL be a multiple of 8, minimum 16.
REQ-002 Parameter DEPTH, default 256, number of words; SHALL be a power of two, minimum 4.
REQ-003 Derived: NB = DATA_W/8 byte lanes; OFS = log2(NB) byte-offset bits; AW = log2(DEPTH) word-index bits.
REQ-004 CLK  input  1  clock; all state updates on rising edge.
REQ-005 RST  input  1  reset, synchronous, active-high.
REQ-006 REQ  input  1  access request, sampled on rising CLK.
REQ-007 WE  input  1  1 = write, 0 = read; qualified by REQ.
REQ-008 BE  input  NB  byte-lane write enables; bit i covers WD[8i+7:8i]; ignored on reads.
REQ-009 A  input  32  byte address.
REQ-010 WD  input  DATA_W  write data.
REQ-011 RD  output  DATA_W  registered read data.
REQ-012 ACK  output  1  one-cycle pulse marking completion of an accepted access.
REQ-013 ERR  output  1  one-cycle pulse, coincident with ACK, marking a faulted access.
REQ-014 BUSY  output  1  high while memory is clearing; requests are not accepted.

Function
REQ-015 FSM states: CLEAR and IDLE only.
REQ-016 CLEAR: one word per cycle is written to zero at index CNT, CNT incrementing from 0; after writing index DEPTH-1 the FSM SHALL move to IDLE on the next edge.
REQ-017 BUSY SHALL equal 1 exactly while state is CLEAR.
REQ-018 REQ while BUSY=1 SHALL be dropped: no memory change, no ACK, no ERR, RD unchanged.
REQ-019 In IDLE, REQ=1 is accepted on that edge; ACK SHALL be 1 in the following cycle only (latency 1), for every accepted request including faulted ones.
REQ-020 Back-to-back: REQ held high for N cycles in IDLE SHALL produce N consecutive ACK cycles.
REQ-021 Word index = A[OFS+AW-1:OFS].
REQ-022 Misaligned fault: A[OFS-1:0] != 0.
REQ-023 Range fault: A[31:OFS+AW] != 0.
REQ-024 On fault: no memory write; RD SHALL be 0; ERR=1 together with ACK.
REQ-025 Write, no fault: for each i with BE[i]=1, byte lane i of the addressed word takes WD lane i; lanes with BE[i]=0 are unchanged; RD SHALL hold its previous value.
REQ-026 Write with BE all zero SHALL be a legal no-op, ACK=1, ERR=0.
REQ-027 Read, no fault: RD SHALL present the addressed word as stored before that edge, in the ACK cycle, and hold until the next accepted read or fault.
REQ-028 Read-after-write: a read accepted the cycle after a write to the same word SHALL return the merged new data.
REQ-029 WD, BE, A, WE SHALL be ignored when REQ=0.

Reset
REQ-030 RST=1 at an edge SHALL force: state=CLEAR, CNT=0, RD=0, ACK=0, ERR=0, BUSY=1.
REQ-031 While RST stays high CNT SHALL remain 0 and no word is cleared; clearing starts at the first edge with RST=0.
REQ-032 RST asserted mid-operation, in either state, SHALL abort it: an ACK pending for the next cycle SHALL NOT appear, and the full clear restarts from index 0.
REQ-033 After RST release, BUSY SHALL fall exactly DEPTH cycles later and every word SHALL read 0.

Verification (DATA_W=32, DEPTH=16)
REQ-034 RST 1 cycle, REQ held high with read A=0x8 -> BUSY=1 for 16 cycles after release, no ACK during them; first accepted read ACKs with RD=0x00000000, ERR=0.
REQ-035 Write A=0x4, BE=4'b1111, WD=0xFFFFFFFF; next cycle read A=0x4 -> ACK each cycle; read returns RD=0xFFFFFFFF; read A=0x8 returns 0x00000000.
REQ-036 Word 0x4 = 0xFFFFFFFF; write BE=4'b0101, WD=0x12345678; read -> RD=0xFF34FF78.
REQ-037 Write A=0x6 (misaligned) and read A=0x40 (out of range) -> both ACK=1, ERR=1, RD=0, memory unchanged (word 1 still 0xFF34FF78).
REQ-038 RST pulsed in the cycle after write A=0x4 is accepted -> no ACK follows, BUSY=1 for 16 cycles, then read A=0x4 returns 0x00000000.

Source files
------------

// File: rtl/data_mem_be_if.sv
// data_mem_be_if: bundles the request/response signals of the byte-enable data memory.
// Latency: none (wiring only); the slave registers rd/ack/err one cycle after acceptance.
// Backpressure: busy high means requests are dropped, not queued; the master must retry.
// Ports: master drives req/we/be/a/wd and observes rd/ack/err/busy; slave is the reverse.
interface data_mem_be_if #(
  parameter int DATA_W = 32
);
  localparam int NB = DATA_W / 8;

  logic              req;   // access request
  logic              we;    // 1 = write, 0 = read
  logic [NB-1:0]     be;    // byte-lane write enables
  logic [31:0]       a;     // byte address
  logic [DATA_W-1:0] wd;    // write data
  logic [DATA_W-1:0] rd;    // registered read data
  logic              ack;   // completion pulse, one cycle after acceptance
  logic              err;   // fault pulse, coincident with ack
  logic              busy;  // memory clearing, requests dropped

  modport master (
    output req, we, be, a, wd,
    input  rd, ack, err, busy
  );

  modport slave (
    input  req, we, be, a, wd,
    output rd, ack, err, busy
  );
endinterface

// File: rtl/data_mem_be.sv
// data_mem_be: single-port word memory with byte-lane writes and self-clear after reset.
// Latency: 1 cycle from accepted request to ack/err/rd; back-to-back requests ack every cycle.
// Backpressure: busy while clearing (DEPTH cycles after reset); requests then are dropped.
// Ports: clk, rst (sync, active-high); bus (slave modport) carries req/we/be/a/wd in and
//        rd/ack/err/busy out.
module data_mem_be #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256
) (
  input  logic         clk,
  input  logic         rst,
  data_mem_be_if.slave bus
);
  localparam int NB  = DATA_W / 8;
  localparam int OFS = $clog2(NB);
  localparam int AW  = $clog2(DEPTH);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [AW-1:0]     cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  // request decode
  logic [AW-1:0] idx;
  logic          misalign;
  logic          out_range;
  logic          fault;

  // output-comb controls
  logic              busy_c;
  logic              accept;
  logic              mem_wen;
  logic [AW-1:0]     mem_widx;
  logic [NB-1:0]     mem_lane;
  logic [DATA_W-1:0] mem_wdat;

  // registered response
  logic [DATA_W-1:0] rd_q;
  logic              ack_q;
  logic              err_q;

  assign idx      = bus.a[OFS+AW-1:OFS];
  assign misalign = |bus.a[OFS-1:0];
  // Shift rather than slice so the check stays legal even when OFS+AW reaches 32.
  assign out_range = (bus.a >> (OFS + AW)) != 32'd0;
  assign fault     = misalign | out_range;

  // ---------------------------------------------------------------- state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_CLEAR;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_CLEAR: begin
        if (cnt == AW'(DEPTH - 1)) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_IDLE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_CLEAR;
      end
    endcase
  end

  // ---------------------------------------------------------------- outputs / controls
  // The clear sweep and normal writes share one write port; they never overlap
  // because requests are only accepted in IDLE.
  always_comb begin
    busy_c   = 1'b0;
    accept   = 1'b0;
    mem_wen  = 1'b0;
    mem_widx = '0;
    mem_lane = '0;
    mem_wdat = '0;
    case (state)
      ST_CLEAR: begin
        busy_c   = 1'b1;
        mem_wen  = 1'b1;
        mem_widx = cnt;
        mem_lane = '1;
        mem_wdat = '0;
      end
      ST_IDLE: begin
        accept = bus.req;
        if (bus.req && bus.we && !fault) begin
          mem_wen  = 1'b1;
          mem_widx = idx;
          mem_lane = bus.be;
          mem_wdat = bus.wd;
        end
      end
      default: begin
        busy_c = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------- clear counter
  // Held at 0 while rst is high so the sweep begins at index 0 on the first free edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (state == ST_CLEAR) begin
      cnt <= cnt + AW'(1);
    end
  end

  // ---------------------------------------------------------------- storage
  // No reset on the array itself; rst only blocks writes, the sweep does the zeroing.
  always_ff @(posedge clk) begin
    if (!rst && mem_wen) begin
      for (int i = 0; i < NB; i++) begin
        if (mem_lane[i]) begin
          mem[mem_widx][8*i +: 8] <= mem_wdat[8*i +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------- response
  // rd changes only on accepted reads (old contents) or faults (zero); writes leave it.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q  <= '0;
      ack_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      ack_q <= accept;
      err_q <= accept && fault;
      if (accept && fault) begin
        rd_q <= '0;
      end else if (accept && !bus.we) begin
        rd_q <= mem[idx];
      end
    end
  end

  assign bus.rd   = rd_q;
  assign bus.ack  = ack_q;
  assign bus.err  = err_q;
  assign bus.busy = busy_c;
endmodule

// File: tb/tb_data_mem_be.sv
// tb_data_mem_be: directed scenarios plus random traffic against a behavioural model.
// Latency: model predicts outputs one edge after each input set.
// Backpressure: model tracks remaining clear cycles and drops requests while busy.
module tb_data_mem_be;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;

  logic clk;
  logic rst;

  data_mem_be_if #(.DATA_W(DATA_W)) bus ();

  data_mem_be #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [31:0] ref_mem [DEPTH];
  int          clear_left;
  logic [31:0] exp_rd;
  logic        exp_ack;
  logic        exp_err;
  bit          armed = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Checks the outputs of the previous edge, then applies new inputs and
  // predicts what the coming edge will produce.
  task automatic step(input bit r, input bit q, input bit w, input logic [3:0] b,
                      input logic [31:0] ad, input logic [31:0] d);
    int word;
    @(negedge clk);
    if (armed) begin
      check("busy", {31'd0, bus.busy}, {31'd0, clear_left > 0});
      check("ack",  {31'd0, bus.ack},  {31'd0, exp_ack});
      check("err",  {31'd0, bus.err},  {31'd0, exp_err});
      check("rd",   bus.rd, exp_rd);
    end
    rst     = r;
    bus.req = q;
    bus.we  = w;
    bus.be  = b;
    bus.a   = ad;
    bus.wd  = d;
    armed   = 1'b1;
    if (r) begin
      clear_left = DEPTH;
      exp_ack    = 1'b0;
      exp_err    = 1'b0;
      exp_rd     = 32'd0;
      for (int k = 0; k < DEPTH; k++) ref_mem[k] = 32'd0;
    end else if (clear_left > 0) begin
      clear_left--;
      exp_ack = 1'b0;
      exp_err = 1'b0;
    end else if (q) begin
      exp_ack = 1'b1;
      if ((ad % 4) != 0 || ad >= 32'(DEPTH * 4)) begin
        exp_err = 1'b1;
        exp_rd  = 32'd0;
      end else begin
        exp_err = 1'b0;
        word    = int'(ad / 4);
        if (w) begin
          for (int i = 0; i < 4; i++)
            if (b[i]) ref_mem[word][8*i +: 8] = d[8*i +: 8];
        end else begin
          exp_rd = ref_mem[word];
        end
      end
    end else begin
      exp_ack = 1'b0;
      exp_err = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  function automatic logic [31:0] rand_addr();
    int sel;
    sel = $urandom_range(0, 9);
    if (sel == 0) return 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
    if (sel == 1) return 32'h40 + 32'($urandom_range(0, 255) * 4);
    if (sel == 2) return $urandom | 32'h8000_0000;
    return 32'($urandom_range(0, DEPTH - 1) * 4);
  endfunction

  initial begin
    rst     = 1'b1;
    bus.req = 1'b0;
    bus.we  = 1'b0;
    bus.be  = 4'h0;
    bus.a   = 32'h0;
    bus.wd  = 32'h0;
    clear_left = DEPTH;
    exp_ack = 1'b0;
    exp_err = 1'b0;
    exp_rd  = 32'd0;

    // reset one cycle, then hold a read of 0x8 through the whole clear
    step(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    for (int k = 0; k < DEPTH + 3; k++) step(1'b0, 1'b1, 1'b0, 4'h0, 32'h8, 32'h0);

    // full write then read-after-write, then read of an untouched word
    step(1'b0, 1'b1, 1'b1, 4'hF, 32'h4, 32'hFFFF_FFFF);
    step(1'b0, 1'b1, 1'b0, 4'h0, 32'h4, 32'h0);
    step(1'b0, 1'b1, 1'b0, 4'h0, 32'h8, 32'h0);

    // partial lanes, then zero-lane no-op write
    step(1'b0, 1'b1, 1'b1, 4'b0101, 32'h4, 32'h1234_5678);
    step(1'b0, 1'b1, 1'b0, 4'h0, 32'h4, 32'h0);
    step(1'b0, 1'b1, 1'b1, 4'b0000, 32'h4, 32'hDEAD_BEEF);
    step(1'b0, 1'b1, 1'b0, 4'hF, 32'h4, 32'h0);

    // faults: misaligned write, out-of-range read, memory untouched
    step(1'b0, 1'b1, 1'b1, 4'hF, 32'h6, 32'hAAAA_AAAA);
    step(1'b0, 1'b1, 1'b0, 4'h0, 32'h40, 32'h0);
    step(1'b0, 1'b1, 1'b0, 4'h0, 32'h4, 32'h0);
    idle(2);

    // reset right after an accepted write: its ack is squashed, clear restarts
    step(1'b0, 1'b1, 1'b1, 4'hF, 32'h4, 32'h5555_5555);
    step(1'b1, 1'b1, 1'b0, 4'h0, 32'h4, 32'h0);
    idle(DEPTH);
    step(1'b0, 1'b1, 1'b0, 4'h0, 32'h4, 32'h0);

    // reset held several cycles and reasserted mid-clear
    step(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 4'hF, 32'h0, 32'h1111_1111);
    idle(5);
    step(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    for (int k = 0; k < DEPTH + 1; k++) step(1'b0, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0);

    // random traffic with occasional reset
    for (int k = 0; k < 600; k++) begin
      step(($urandom_range(0, 149) == 0), ($urandom_range(0, 3) != 0), $urandom_range(0, 1),
           4'($urandom), rand_addr(), $urandom);
    end

    // sweep every word after random traffic
    idle(DEPTH + 1);
    for (int k = 0; k < DEPTH; k++) step(1'b0, 1'b1, 1'b0, 4'h0, 32'(k * 4), 32'h0);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
